// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave oversampled in the clk domain, all four modes, WIDTH-bit words.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err and tx_underrun pulse outputs.
module spi_slave_rx #(
    parameter int unsigned MODE        = 0,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic             frame_err,
    output logic             tx_underrun
`endif
);

    localparam int unsigned      CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic             CPOL  = ((MODE >> 1) & 1) != 0;
    localparam logic             CPHA  = (MODE & 1) != 0;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    state_t             state_q;
    logic               busy_q;
    logic               miso_q;
    logic [WIDTH-1:0]   rx_data_q;
    logic               rx_valid_q;
    logic [WIDTH-1:0]   rx_shift_q;
    logic [WIDTH-1:0]   tx_shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               first_q;
    logic [WIDTH-1:0]   tx_buf_q;
    logic               tx_pend_q;
    logic               ld_hold_q;
    logic [WIDTH-1:0]   ld_data_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic               frame_err_q;
    logic               tx_underrun_q;
`endif

    logic               sclk_s;
    logic               cs_s;
    logic               mosi_s;
    logic               lead_edge;
    logic               trail_edge;
    logic               cs_fall;
    logic               cs_rise;
    logic               do_sample_d;
    logic               do_shift_d;
    logic               reload_d;
    logic               tx_load_ok;
    logic [WIDTH-1:0]   word_src_d;
    logic [WIDTH-1:0]   tx_src_d;
    logic               tx_bit_d;
    logic [WIDTH-1:0]   tx_rest_d;
    logic [WIDTH-1:0]   rx_next_d;
    logic [CNT_W-1:0]   cnt_next_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
        trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
        cs_fall     = cs_prev_q && !cs_s;
        cs_rise     = !cs_prev_q && cs_s;
        do_sample_d = (state_q == ACTIVE) && (CPHA ? trail_edge : lead_edge);
        // A shift edge racing the deselect is dropped so miso returns to 0.
        do_shift_d  = (state_q == ACTIVE) && (CPHA ? lead_edge : trail_edge) && !cs_rise;
        reload_d    = ((state_q == IDLE) && cs_fall) ||
                      (do_shift_d && (bit_cnt_q == '0) && !first_q);
        tx_load_ok  = tx_load && tx_ready;
        word_src_d  = tx_pend_q ? tx_buf_q : '0;
        tx_src_d    = reload_d ? word_src_d : tx_shift_q;
        if (MSB_FIRST != 0) begin
            tx_bit_d  = tx_src_d[WIDTH-1];
            tx_rest_d = {tx_src_d[WIDTH-2:0], 1'b0};
            rx_next_d = {rx_shift_q[WIDTH-2:0], mosi_s};
        end else begin
            tx_bit_d  = tx_src_d[0];
            tx_rest_d = {1'b0, tx_src_d[WIDTH-1:1]};
            rx_next_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
        end
        cnt_next_d  = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            first_q       <= 1'b0;
            tx_buf_q      <= '0;
            tx_pend_q     <= 1'b0;
            ld_hold_q     <= 1'b0;
            ld_data_q     <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q   <= 1'b0;
            tx_underrun_q <= reload_d && !tx_pend_q && (state_q == ACTIVE);
`endif
            if (reload_d) begin
                tx_pend_q <= 1'b0;
            end
            // A load that collides with a reload is parked one clk so the reload sees the old buffer.
            if (ld_hold_q) begin
                tx_buf_q  <= ld_data_q;
                tx_pend_q <= 1'b1;
                ld_hold_q <= 1'b0;
            end else if (tx_load_ok) begin
                if (reload_d) begin
                    ld_hold_q <= 1'b1;
                    ld_data_q <= tx_data;
                end else begin
                    tx_buf_q  <= tx_data;
                    tx_pend_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= ACTIVE;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        first_q   <= CPHA;
                        if (CPHA) begin
                            tx_shift_q <= tx_src_d;
                        end else begin
                            miso_q     <= tx_bit_d;
                            tx_shift_q <= tx_rest_d;
                        end
                    end
                end
                ACTIVE: begin
                    if (do_sample_d) begin
                        rx_shift_q <= rx_next_d;
                        bit_cnt_q  <= cnt_next_d;
                        if (bit_cnt_q == LAST) begin
                            rx_data_q  <= rx_next_d;
                            rx_valid_q <= 1'b1;
                        end
                    end
                    if (do_shift_d) begin
                        miso_q     <= tx_bit_d;
                        tx_shift_q <= tx_rest_d;
                        first_q    <= 1'b0;
                    end
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        miso_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        first_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err_q <= (do_sample_d ? cnt_next_d : bit_cnt_q) != '0;
`endif
                    end
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign tx_ready = !tx_pend_q && !ld_hold_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err   = frame_err_q;
    assign tx_underrun = tx_underrun_q;
`endif

endmodule
